// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory burst arbiter.
// The arbitration policy is selected with the ARB_FIXED_PRIO_EN macro (see rr_arbiter).
package dmem_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } arb_state_t;

  localparam int LEN_W           = 4;
  localparam int DEF_DATA_W      = 256;
  localparam int DEF_ADDR_W      = 10;
  localparam int DEF_NUM_REQ     = 2;
  localparam int DEF_MAX_BURST   = 8;
  localparam int DEF_ADDR_STRIDE = 4;

  // Index width that stays legal for a single requester.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational requester selection: round-robin from ptr by default,
// fixed lowest-index-wins priority when ARB_FIXED_PRIO_EN is defined.
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IDX_W  = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  assign any_req = |req;

`ifdef ARB_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    grant_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant_idx = IDX_W'(i);
      end
    end
  end
`else
  logic found;

  // Search starts at ptr, so the last-served requester is considered last.
  always_comb begin
    grant_idx = '0;
    found     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
        found     = 1'b1;
        grant_idx = IDX_W'((int'(ptr) + i) % NUM_REQ);
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (any_req) begin
      grant = NUM_REQ'(1) << grant_idx;
    end
  end

endmodule

// File: rtl/dmem_burst_arbiter.sv
// Burst arbiter sharing one single-port data memory between NUM_REQ requesters.
// Define ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module dmem_burst_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int MAX_BURST   = DEF_MAX_BURST,
  parameter int ADDR_STRIDE = DEF_ADDR_STRIDE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*LEN_W-1:0]  req_len,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        beat_ack,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      busy,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int IDX_W = idx_w(NUM_REQ);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BURST - 1);

  logic [ADDR_W-1:0] addr_arr  [NUM_REQ];
  logic [LEN_W-1:0]  len_arr   [NUM_REQ];
  logic [DATA_W-1:0] wdata_arr [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
      assign len_arr[gi]   = req_len[gi*LEN_W +: LEN_W];
      assign wdata_arr[gi] = req_wdata[gi*DATA_W +: DATA_W];
    end
  endgenerate

  arb_state_t        state_reg, state_next;
  logic [IDX_W-1:0]  ptr_reg;
  logic [IDX_W-1:0]  gnt_reg;
  logic              rd_we_q;
  logic [ADDR_W-1:0] cur_addr;
  logic [LEN_W-1:0]  beats_left;
  logic [NUM_REQ-1:0] rsp_valid_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;

  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [LEN_W-1:0]   len_clamped;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic [IDX_W-1:0]   ptr_next;
  logic               last_beat;
  logic               read_beat;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req       (req_valid),
    .ptr       (ptr_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

  always_comb begin
    len_clamped = len_arr[arb_idx];
    if (len_clamped > LEN_MAX) begin
      len_clamped = LEN_MAX;
    end
  end

  assign gnt_onehot = NUM_REQ'(1) << gnt_reg;
  assign ptr_next   = (gnt_reg == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_reg + IDX_W'(1);
  assign last_beat  = (beats_left == '0);
  assign read_beat  = (state_reg == BURST) && !rd_we_q;

  always_comb begin
    state_next = state_reg;
    req_ready  = '0;
    beat_ack   = '0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_reg)
      IDLE: begin
        if (arb_any) begin
          req_ready  = arb_grant;
          state_next = BURST;
        end
      end
      BURST: begin
        beat_ack = gnt_onehot;
        mem_addr = cur_addr;
        mem_we   = rd_we_q;
        if (rd_we_q) begin
          mem_wdata = wdata_arr[gnt_reg];
        end
        if (last_beat) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    // Keep the handshake silent while reset is held, since req_valid may still be high.
    req_ready = req_ready & {NUM_REQ{rst}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      ptr_reg       <= '0;
      gnt_reg       <= '0;
      rd_we_q       <= 1'b0;
      cur_addr      <= '0;
      beats_left    <= '0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      rsp_valid_reg <= read_beat ? gnt_onehot : '0;
      if (read_beat) begin
        rsp_rdata_reg <= mem_rdata;
      end
      case (state_reg)
        IDLE: begin
          if (arb_any) begin
            gnt_reg    <= arb_idx;
            rd_we_q    <= req_we[arb_idx];
            cur_addr   <= addr_arr[arb_idx];
            beats_left <= len_clamped;
          end
        end
        BURST: begin
          cur_addr   <= cur_addr + ADDR_W'(ADDR_STRIDE);
          beats_left <= beats_left - LEN_W'(1);
          if (last_beat) begin
            ptr_reg <= ptr_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state_reg == BURST);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;

endmodule

// File: tb/tb_dmem_burst_arbiter.sv
// Directed bench for dmem_burst_arbiter with a behavioural 1024x256 memory.
module tb_dmem_burst_arbiter;
  localparam int DW = 256;
  localparam int AW = 10;
  localparam int NR = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   req_we;
  logic [NR*AW-1:0] req_addr;
  logic [NR*4-1:0] req_len;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   beat_ack;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            busy;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;

  logic [DW-1:0] mem [1024];

  int checks = 0;
  int failures = 0;
  int cnt;

  always #5 clk = ~clk;

  dmem_burst_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_len   (req_len),
    .req_wdata (req_wdata),
    .beat_ack  (beat_ack),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  function automatic logic [DW-1:0] pat(input int i);
    return {8{32'hD000_0000 | 32'(i)}};
  endfunction

  function automatic logic [DW-1:0] bd(input int b);
    return {8{32'h5A5A_0000 | 32'(b)}};
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_len = '0; req_wdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = pat(i);

    // Reset: outputs quiet even with a request pending
    req_valid = 2'b01;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_beat_ack", beat_ack, 0);
    req_valid = '0;
    rst = 1'b1;
    tick();

    // Read burst: req0, addr 100, len 1
    req_valid = 2'b01; req_we = 2'b00; req_addr[9:0] = 10'd100; req_len[3:0] = 4'd1;
    @(negedge clk);
    chk("t1_ready", req_ready, 2'b01);
    chk("t1_idle_busy", busy, 0);
    tick();
    req_valid = '0; req_addr[9:0] = 10'd500; req_len[3:0] = 4'd7;
    @(negedge clk);
    chk("t1_ack0", beat_ack, 2'b01);
    chk("t1_addr0", mem_addr, 100);
    chk("t1_we0", mem_we, 0);
    chk("t1_busy", busy, 1);
    chk("t1_rv0", rsp_valid, 0);
    tick(); @(negedge clk);
    chk("t1_addr1", mem_addr, 104);
    chk("t1_rv1", rsp_valid, 2'b01);
    chk("t1_rd1", rsp_rdata, pat(100));
    tick(); @(negedge clk);
    chk("t1_end_busy", busy, 0);
    chk("t1_end_ack", beat_ack, 0);
    chk("t1_rv2", rsp_valid, 2'b01);
    chk("t1_rd2", rsp_rdata, pat(104));
    tick(); @(negedge clk);
    chk("t1_rv3", rsp_valid, 0);

    // Write burst: req1, addr 8, len 0
    tick();
    req_valid = 2'b10; req_we = 2'b10; req_addr[19:10] = 10'd8; req_len[7:4] = 4'd0;
    req_wdata[511:256] = {32{8'hAB}};
    @(negedge clk);
    chk("t2_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t2_we", mem_we, 1);
    chk("t2_addr", mem_addr, 8);
    chk("t2_wdata", mem_wdata, {32{8'hAB}});
    chk("t2_ack", beat_ack, 2'b10);
    tick(); @(negedge clk);
    chk("t2_end_we", mem_we, 0);
    chk("t2_end_wdata", mem_wdata, 0);
    tick();
    req_valid = 2'b01; req_we = 2'b00; req_addr[9:0] = 10'd8; req_len[3:0] = 4'd0;
    @(negedge clk);
    chk("t2_rb_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t2_rb_addr", mem_addr, 8);
    tick(); @(negedge clk);
    chk("t2_rb_rv", rsp_valid, 2'b01);
    chk("t2_rb_rd", rsp_rdata, {32{8'hAB}});

    // Reset pulse restores requester 0 as highest priority
    tick();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Both requesting continuously, len 0: grants alternate 0,1,0,1
    tick();
    req_valid = 2'b11; req_we = 2'b00; req_addr = {10'd4, 10'd0}; req_len = 8'h00;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] e;
      e = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      chk("t3_ready", req_ready, e);
      tick(); @(negedge clk);
      chk("t3_ack", beat_ack, e);
      tick();
    end
    req_valid = '0;

    // Address wrap: req0 read 1020, len 2
    req_valid = 2'b01; req_addr[9:0] = 10'd1020; req_len[3:0] = 4'd2;
    @(negedge clk);
    chk("t4_ready", req_ready, 2'b01);
    tick();
    req_valid = '0;
    @(negedge clk);
    chk("t4_addr0", mem_addr, 1020);
    tick(); @(negedge clk);
    chk("t4_addr1", mem_addr, 0);
    chk("t4_rd0", rsp_rdata, pat(1020));
    tick(); @(negedge clk);
    chk("t4_addr2", mem_addr, 4);
    chk("t4_rd1", rsp_rdata, pat(0));
    tick(); @(negedge clk);
    chk("t4_end_busy", busy, 0);
    chk("t4_rd2", rsp_rdata, pat(4));

    // Length clamp: req1 len 15 gives 8 beats
    tick();
    req_valid = 2'b10; req_we = 2'b00; req_addr[19:10] = 10'd40; req_len[7:4] = 4'd15;
    @(negedge clk);
    chk("t5_ready", req_ready, 2'b10);
    tick();
    req_valid = '0;
    cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (beat_ack[1]) cnt++;
      tick();
    end
    chk("t5_beats", cnt, 8);
    chk("t5_end_busy", busy, 0);

    // Reset during beat 3 of a 5-beat write at 200
    req_valid = 2'b01; req_we = 2'b01; req_addr[9:0] = 10'd200; req_len[3:0] = 4'd4;
    @(negedge clk);
    chk("t6_ready", req_ready, 2'b01);
    tick();
    req_valid = '0; req_wdata[255:0] = bd(0);
    @(negedge clk);
    chk("t6_we0", mem_we, 1);
    chk("t6_addr0", mem_addr, 200);
    chk("t6_wd0", mem_wdata, bd(0));
    tick();
    req_wdata[255:0] = bd(1);
    @(negedge clk);
    chk("t6_addr1", mem_addr, 204);
    tick();
    req_wdata[255:0] = bd(2);
    #1 rst = 1'b0;
    #1;
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ack", beat_ack, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_wdata", mem_wdata, 0);
    chk("t6_rst_rv", rsp_valid, 0);
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(); @(negedge clk);
      chk("t6_post_idle", {busy, mem_we, beat_ack}, 0);
    end
    chk("t6_mem200", mem[200], bd(0));
    chk("t6_mem204", mem[204], bd(1));
    chk("t6_mem208", mem[208], pat(208));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
